// File: rtl/hba_master_port_pkg.sv
// Shared definitions for the HBA master port: default bus widths
// and the 2-bit FSM state encoding.
package hba_master_port_pkg;

    localparam int HBA_DBUS_W = 8;
    localparam int HBA_ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_XFER = 2'b10,
        ST_RESP = 2'b11
    } hba_state_e;

endpackage

// File: rtl/hba_master_port.sv
// HBA bus-master front end: takes one register read/write command,
// requests the bus, runs a single transfer guarded by a watchdog and
// returns status and read data.
// Ports: hba_clk/hba_reset; cmd_* command handshake in; rsp_* response
// handshake out; hba_mrequest/hba_mgrant to the arbiter; hba_*_out
// bus drive (zero unless selected); hba_xferDone/hba_dbus from slave.
module hba_master_port
    import hba_master_port_pkg::*;
#(
    parameter int DBUS_WIDTH = HBA_DBUS_W,
    parameter int ADDR_WIDTH = HBA_ADDR_W,
    parameter int TIMEOUT    = 255
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DBUS_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DBUS_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  hba_mrequest,
    input  logic                  hba_mgrant,
    output logic                  hba_select_out,
    output logic [ADDR_WIDTH-1:0] hba_abus_out,
    output logic                  hba_rnw_out,
    output logic [DBUS_WIDTH-1:0] hba_dbus_out,
    input  logic                  hba_xferDone,
    input  logic [DBUS_WIDTH-1:0] hba_dbus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    hba_state_e state, state_d;

    logic                  lat_rnw;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DBUS_WIDTH-1:0] lat_wdata;
    logic [CW-1:0]         wd_cnt;

    logic accept;
    logic done;
    logic tmo;

    // Next state and transfer events; xferDone takes priority over
    // the watchdog when both land in the same cycle.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        done    = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (hba_mgrant) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (hba_xferDone) begin
                    done    = 1'b1;
                    state_d = ST_RESP;
                end else if (wd_cnt == TMO) begin
                    tmo     = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every output is a register loaded from the next state, so it
    // changes on the same edge as the state it belongs to.
    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            hba_mrequest   <= 1'b0;
            hba_select_out <= 1'b0;
            hba_abus_out   <= '0;
            hba_rnw_out    <= 1'b0;
            hba_dbus_out   <= '0;
            lat_rnw        <= 1'b0;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            wd_cnt         <= '0;
        end else begin
            state          <= state_d;
            cmd_ready      <= (state_d == ST_IDLE);
            hba_mrequest   <= (state_d == ST_REQ);
            hba_select_out <= (state_d == ST_XFER);
            rsp_valid      <= (state_d == ST_RESP);

            if (accept) begin
                lat_rnw   <= cmd_rnw;
                lat_addr  <= cmd_addr;
                lat_wdata <= cmd_wdata;
            end

            // The bus is OR-combined, so drive zeros unless selected.
            if (state_d == ST_XFER) begin
                hba_abus_out <= lat_addr;
                hba_rnw_out  <= lat_rnw;
                hba_dbus_out <= lat_wdata;
            end else begin
                hba_abus_out <= '0;
                hba_rnw_out  <= 1'b0;
                hba_dbus_out <= '0;
            end

            // Zero outside XFER, so it starts from 0 on entry.
            if (state == ST_XFER) begin
                wd_cnt <= wd_cnt + CW'(1);
            end else begin
                wd_cnt <= '0;
            end

            if (done) begin
                rsp_rdata <= lat_rnw ? hba_dbus : '0;
                rsp_err   <= 1'b0;
            end else if (tmo) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end else if (state == ST_RESP && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule
